// File: rtl/led_shift_pkg.sv
// Shared constants and helpers for the four-mode LED shift sequencer.
// Optional build macro used by the top: LED_ACTIVE_LOW_EN (inverts the LED port).
package led_shift_pkg;

  // Pattern mode encodings as seen on the MODE input.
  localparam logic [1:0] MODE_FILL_LSB  = 2'd0;
  localparam logic [1:0] MODE_DRAIN_MSB = 2'd1;
  localparam logic [1:0] MODE_DRAIN_LSB = 2'd2;
  localparam logic [1:0] MODE_FILL_MSB  = 2'd3;

  // Whole-bank pattern constants.
  localparam logic [7:0] LED_ALL_OFF = 8'h00;
  localparam logic [7:0] LED_ALL_ON  = 8'hFF;

  // Fill modes start dark, drain modes start fully lit.
  function automatic logic [7:0] start_pattern(input logic [1:0] mode);
    logic [7:0] pat;
    case (mode)
      MODE_FILL_LSB:  pat = LED_ALL_OFF;
      MODE_DRAIN_MSB: pat = LED_ALL_ON;
      MODE_DRAIN_LSB: pat = LED_ALL_ON;
      MODE_FILL_MSB:  pat = LED_ALL_OFF;
      default:        pat = LED_ALL_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// Step-rate prescaler: counts clocks while SS is high and flags a tick on the
// last count of each STEP_DIV-long period. The count freezes while SS is low.
module led_step_prescaler #(
  parameter int STEP_DIV = 1
) (
  input  logic Clk,
  input  logic RST,
  input  logic SS,
  output logic tick
);

  localparam int               CNT_W    = $clog2(STEP_DIV + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = SS && (cnt_q == LAST_CNT);

  // Next count: wrap on the tick, advance while running, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (SS) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler count register, cleared asynchronously by reset.
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_shift_four_mode.sv
// Eight-LED pattern sequencer with four fill/drain modes, stepped by a
// prescaled tick. Build macro LED_ACTIVE_LOW_EN drives the LED port inverted
// for active-low boards; sequencing itself is unaffected.
module led_shift_four_mode
  import led_shift_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic       SS,
  input  logic [1:0] MODE,
  output logic [7:0] LED
);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic [7:0] LED_POLARITY = 8'hFF;
`else
  localparam logic [7:0] LED_POLARITY = 8'h00;
`endif

  logic       tick_s;
  logic [1:0] mode_q;
  logic [1:0] mode_d;
  logic [7:0] led_q;
  logic [7:0] led_d;
  logic [7:0] led_next_s;

  led_step_prescaler #(
    .STEP_DIV (STEP_DIV)
  ) u_prescaler (
    .Clk  (Clk),
    .RST  (RST),
    .SS   (SS),
    .tick (tick_s)
  );

  // Next pattern within the current mode; each mode wraps in a single step.
  always_comb begin
    led_next_s = led_q;
    case (mode_q)
      MODE_FILL_LSB:  led_next_s = (led_q == LED_ALL_ON)  ? LED_ALL_OFF : {led_q[6:0], 1'b1};
      MODE_DRAIN_MSB: led_next_s = (led_q == LED_ALL_OFF) ? LED_ALL_ON  : {1'b0, led_q[7:1]};
      MODE_DRAIN_LSB: led_next_s = (led_q == LED_ALL_OFF) ? LED_ALL_ON  : {led_q[6:0], 1'b0};
      MODE_FILL_MSB:  led_next_s = (led_q == LED_ALL_ON)  ? LED_ALL_OFF : {1'b1, led_q[7:1]};
      default:        led_next_s = LED_ALL_OFF;
    endcase
  end

  // On a tick a new mode only reloads its start pattern; otherwise advance.
  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
    if (tick_s) begin
      if (MODE != mode_q) begin
        mode_d = MODE;
        led_d  = start_pattern(MODE);
      end else begin
        led_d  = led_next_s;
      end
    end else begin
      mode_d = mode_q;
      led_d  = led_q;
    end
  end

  // Mode and pattern registers, cleared asynchronously by reset.
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      mode_q <= MODE_FILL_LSB;
      led_q  <= LED_ALL_OFF;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
    end
  end

  // Port polarity is a constant mask on the registered pattern.
  assign LED = led_q ^ LED_POLARITY;

endmodule

// File: tb/tb_led_shift_four_mode.sv
// Self-checking bench: two sequencer instances (STEP_DIV=1 and STEP_DIV=4)
// share stimulus; a table-driven reference model predicts each LED port.
module tb_led_shift_four_mode;

  logic       Clk;
  logic       RST;
  logic       SS;
  logic [1:0] MODE;
  logic [7:0] led1;
  logic [7:0] led4;

  int n_cmp;
  int n_fail;

  // Reference sequences: index 0 is each mode's start pattern, 9-step period.
  logic [7:0] seq [4][9] = '{
    '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF},
    '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00},
    '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00},
    '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF}
  };

  // Model state per instance: 0 -> STEP_DIV=1, 1 -> STEP_DIV=4.
  int div_m  [2] = '{1, 4};
  int mode_m [2];
  int idx_m  [2];
  int cnt_m  [2];

  led_shift_four_mode #(.STEP_DIV(1)) u_dut1 (
    .Clk (Clk), .RST (RST), .SS (SS), .MODE (MODE), .LED (led1)
  );

  led_shift_four_mode #(.STEP_DIV(4)) u_dut4 (
    .Clk (Clk), .RST (RST), .SS (SS), .MODE (MODE), .LED (led4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [7:0] port_val(input logic [7:0] pat);
`ifdef LED_ACTIVE_LOW_EN
    return ~pat;
`else
    return pat;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mode_m[d] = 0;
      idx_m[d]  = 0;
      cnt_m[d]  = 0;
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_div1"}, led1, port_val(seq[mode_m[0]][idx_m[0]]));
    check({tag, "_div4"}, led4, port_val(seq[mode_m[1]][idx_m[1]]));
  endtask

  // One clock: model follows the inputs present at the edge, then compare.
  task automatic step(input string tag);
    @(posedge Clk);
    if (!RST) begin
      model_reset();
    end else if (SS) begin
      for (int d = 0; d < 2; d++) begin
        if (cnt_m[d] == div_m[d] - 1) begin
          cnt_m[d] = 0;
          if (int'(MODE) != mode_m[d]) begin
            mode_m[d] = int'(MODE);
            idx_m[d]  = 0;
          end else begin
            idx_m[d] = (idx_m[d] + 1) % 9;
          end
        end else begin
          cnt_m[d] = cnt_m[d] + 1;
        end
      end
    end
    #1;
    check_both(tag);
  endtask

  // Pull reset low between edges and confirm the port clears immediately.
  task automatic async_reset(input string tag);
    #3;
    RST = 1'b0;
    #1;
    model_reset();
    check_both(tag);
    check({tag, "_const"}, led1, port_val(8'h00));
    step({tag, "_hold"});
    RST = 1'b1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    model_reset();
    RST  = 1'b0;
    SS   = 1'b0;
    MODE = 2'd0;

    // Reset held for two clocks.
    step("rst0");
    step("rst1");
    check("rst_port", led1, port_val(8'h00));
    RST = 1'b1;
    SS  = 1'b1;

    // Mode 0 full period plus wrap, then up to 07.
    for (int i = 0; i < 12; i++) step("mode0");
    check("mode0_at07", led1, port_val(8'h07));

    // Switch modes mid-run, running each through a wrap.
    MODE = 2'd1;
    for (int i = 0; i < 10; i++) step("mode1");
    MODE = 2'd2;
    for (int i = 0; i < 10; i++) step("mode2");
    MODE = 2'd3;
    for (int i = 0; i < 4; i++) step("mode3");
    check("mode3_atE0", led1, port_val(8'hE0));

    // Pause holds the pattern; resume advances on the next clock.
    SS = 1'b0;
    for (int i = 0; i < 5; i++) step("pause");
    check("pause_hold", led1, port_val(8'hE0));
    SS = 1'b1;
    step("resume");
    check("resume_F0", led1, port_val(8'hF0));

    // Mode 0 up to 3F, then asynchronous reset mid-cycle.
    MODE = 2'd0;
    for (int i = 0; i < 7; i++) step("mode0b");
    check("mode0b_at3F", led1, port_val(8'h3F));
    async_reset("areset");

    // Restart after reset in mode 2 reloads its start pattern first.
    MODE = 2'd2;
    for (int i = 0; i < 12; i++) step("post_rst");

    // Randomized stretch with pauses, mode changes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      SS = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) MODE = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rand_rst");
      end else begin
        step("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
